mem_io_ctrl: RTL and testbench
==============================

// Module: mem_io_ctrl
// PURPOSE
//  Parametrised external-SRAM and memory-mapped-I/O controller for the SLC-3 family.
//  Takes single-request CPU accesses (req/ack handshake) and sequences active-low SRAM
//  strobes with configurable wait states. Addresses at the I/O window go to on-chip
//  switch/hex/LED registers instead. Sits between the ISDU/datapath (MAR/MDR) and the
//  split tristate SRAM data bus.
// PARAMETERS
//  DATA_W       16        CPU and SRAM data width (even; UB/LB cover upper/lower halves)
//  ADDR_W       16        CPU address width
//  SRAM_ADDR_W  20        SRAM address width (>= ADDR_W; upper bits zero-filled)
//  WAIT_STATES  2         extra strobe cycles per SRAM access (0..15)
//  NUM_HEX      4         hex digits held by the display register
//  LED_W        12        LED register width (<= DATA_W)
//  IO_SW_ADDR   'hFFFF    read: switches; write: hex register
//  IO_LED_ADDR  'hFFFE    read/write: LED register
// PORTS
//  Clk      in   1              system clock, rising edge
//  Reset    in   1              asynchronous, active-high
//  req      in   1              access request, sampled only in IDLE
//  we       in   1              1 = write, 0 = read
//  be       in   2              byte enables {upper,lower}; apply to SRAM writes only
//  addr     in   ADDR_W         CPU address
//  wdata    in   DATA_W         write data
//  rdata    out  DATA_W         read data, held until the next read completes
//  ack      out  1              one-cycle completion pulse
//  busy     out  1              high in every state except IDLE
//  Switches in   DATA_W         board switches
//  HEX      out  NUM_HEX*4      hex-digit nibbles, digit 0 = LSBs
//  LED      out  LED_W          LED register
//  CE,OE,WE,UB,LB out 1         SRAM strobes, active-low
//  ADDR     out  SRAM_ADDR_W    SRAM address, registered
//  Data_out out  DATA_W         data to the tristate driver
//  Data_oe  out  1              drive enable for the tristate driver
//  Data_in  in   DATA_W         data from the SRAM bus
// BEHAVIOUR
//  Reset (async): state=IDLE; CE/OE/WE/UB/LB=1; ADDR, Data_out, rdata, HEX, LED = 0;
//   Data_oe=0; ack=0; busy=0. Reset mid-access aborts it in the same instant: strobes
//   deassert, and the aborted access never produces ack.
//  FSM states: IDLE, IO, RD, WR_SETUP, WR, WR_HOLD, DONE. Request fields latch on the
//   accepting edge. All strobes are registered outputs, so the FSM is glitch-free.
//  IDLE + req: if addr is IO_SW_ADDR or IO_LED_ADDR, go to IO; else if we, go to
//   WR_SETUP; else go to RD.
//  IO (1 cycle): a write to IO_SW_ADDR loads HEX <= wdata[NUM_HEX*4-1:0] (zero-filled if
//   NUM_HEX*4 > DATA_W). A write to IO_LED_ADDR loads LED <= wdata[LED_W-1:0]. A read of
//   IO_SW_ADDR returns Switches; a read of IO_LED_ADDR returns LED zero-extended.
//   be is ignored. Go to DONE.
//  RD (WAIT_STATES+1 cycles): CE=OE=UB=LB=0; wait counter runs. Sample Data_in into
//   rdata on the last RD cycle, then go to DONE.
//  WR_SETUP (1 cycle): CE=0, address and Data_out valid, Data_oe=1, WE=1.
//  WR (WAIT_STATES+1 cycles): WE=0; UB=~be[1], LB=~be[0].
//  WR_HOLD (1 cycle): WE=1, data still driven.
//   be=2'b00 still runs the full cycle with UB=LB=1 (a no-op write).
//  DONE (1 cycle): ack=1, all strobes deasserted, Data_oe=0; return to IDLE.
//  Latency from the accepting edge to ack high: IO 2 cycles, read WAIT_STATES+2,
//   write WAIT_STATES+4.
//  req held high through ack starts a new access on the first IDLE cycle after DONE
//   (back-to-back). req in any non-IDLE state is ignored; no queueing.
//  Writes leave rdata unchanged. ADDR = {zeros, addr}, updated on acceptance and held
//   until the next acceptance.
//  Data_oe and OE=0 are never both asserted (no bus contention).
//  WE=0 only inside WR, and never in the first or last cycle CE=0 is asserted.
// STRUCTURE
//  Package mem_io_pkg holds: state enum mem_state_t; default IO_SW_ADDR/IO_LED_ADDR
//   constants; function wait_cnt_w(WAIT_STATES) = max(1, $clog2(WAIT_STATES+1)).
//  One sub-module, mem_io_regs: HEX and LED registers plus the I/O read mux.
//  The FSM, wait counter and SRAM strobes stay in mem_io_ctrl. The tristate driver
//   stays outside.
// TESTING
//  1 SRAM read, WAIT_STATES=2, addr='h0030, SRAM model returns 'hBEEF -> ack 4 cycles
//    after acceptance; rdata='hBEEF; OE low for exactly 3 cycles; ADDR='h00030.
//  2 SRAM write 'h1234 to 'h0040 with be=2'b01 -> WE low 3 cycles inside CE low;
//    LB=0, UB=1; ack at cycle 6; Data_oe deasserted in DONE; model upper byte unchanged.
//  3 Write 'h00A5 to 'hFFFF -> HEX='h00A5 after 2 cycles, no SRAM strobe. Read 'hFFFF
//    with Switches='h5A5A -> rdata='h5A5A. Write 'hFFFE with 'hFFFF -> LED='hFFF.
//  4 req held high for 3 reads, WAIT_STATES=0 -> ack every 3rd cycle; busy low exactly
//    one cycle between accesses; req pulses while busy are ignored.
//  5 Reset asserted in WR cycle 2 -> WE, CE and Data_oe go high without waiting for
//    Clk; no ack; first access after release completes normally.
//  6 Assertion checks across random traffic with WAIT_STATES in {0,1,5}: Data_oe and
//    ~OE never both high; ack never lasts more than 1 cycle.

Source files
------------

// File: rtl/mem_io_pkg.sv
// Shared types and defaults for the SLC-3 SRAM / memory-mapped I/O controller.
package mem_io_pkg;

    typedef enum logic [2:0] {
        IDLE,
        IO,
        RD,
        WR_SETUP,
        WR,
        WR_HOLD,
        DONE
    } mem_state_t;

    localparam int unsigned IO_SW_ADDR_DEF  = 32'h0000_FFFF;
    localparam int unsigned IO_LED_ADDR_DEF = 32'h0000_FFFE;

    // Wait counter width; at least one bit so a zero-wait build still has a counter.
    function automatic int unsigned wait_cnt_w(input int unsigned wait_states);
        int unsigned w;
        w = $clog2(wait_states + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mem_io_regs.sv
// Hex-display and LED registers behind the I/O window, plus the I/O read mux.
module mem_io_regs
    import mem_io_pkg::*;
#(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned NUM_HEX = 4,
    parameter int unsigned LED_W   = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic                   sel_sw,
    input  logic [DATA_W-1:0]      wdata,
    input  logic [DATA_W-1:0]      sw,
    output logic [NUM_HEX*4-1:0]   hex,
    output logic [LED_W-1:0]       led,
    output logic [DATA_W-1:0]      rd_data_c
);

    localparam int unsigned HEX_W = NUM_HEX * 4;

    logic [HEX_W-1:0] hex_q, hex_d;
    logic [LED_W-1:0] led_q, led_d;

    // The switch address doubles as the hex register on writes.
    always_comb begin
        hex_d = hex_q;
        led_d = led_q;
        if (wr_en) begin
            if (sel_sw) begin
                hex_d = HEX_W'(wdata);
            end else begin
                led_d = LED_W'(wdata);
            end
        end
        rd_data_c = sel_sw ? sw : DATA_W'(led_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hex_q <= '0;
            led_q <= '0;
        end else begin
            hex_q <= hex_d;
            led_q <= led_d;
        end
    end

    assign hex = hex_q;
    assign led = led_q;

endmodule

// File: rtl/mem_io_ctrl.sv
// Single-request CPU access sequencer for external async SRAM with an on-chip I/O window.
module mem_io_ctrl
    import mem_io_pkg::*;
#(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned SRAM_ADDR_W = 20,
    parameter int unsigned WAIT_STATES = 2,
    parameter int unsigned NUM_HEX     = 4,
    parameter int unsigned LED_W       = 12,
    parameter int unsigned IO_SW_ADDR  = IO_SW_ADDR_DEF,
    parameter int unsigned IO_LED_ADDR = IO_LED_ADDR_DEF
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   req,
    input  logic                   we,
    input  logic [1:0]             be,
    input  logic [ADDR_W-1:0]      addr,
    input  logic [DATA_W-1:0]      wdata,
    output logic [DATA_W-1:0]      rdata,
    output logic                   ack,
    output logic                   busy,
    input  logic [DATA_W-1:0]      Switches,
    output logic [NUM_HEX*4-1:0]   HEX,
    output logic [LED_W-1:0]       LED,
    output logic                   CE,
    output logic                   OE,
    output logic                   WE,
    output logic                   UB,
    output logic                   LB,
    output logic [SRAM_ADDR_W-1:0] ADDR,
    output logic [DATA_W-1:0]      Data_out,
    output logic                   Data_oe,
    input  logic [DATA_W-1:0]      Data_in
);

    localparam int unsigned     WC_W    = wait_cnt_w(WAIT_STATES);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(WAIT_STATES);

    mem_state_t             state_q, state_d;
    logic [WC_W-1:0]        cnt_q, cnt_d;
    logic                   we_q, we_d;
    logic [1:0]             be_q, be_d;
    logic                   sel_sw_q, sel_sw_d;
    logic [SRAM_ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0]      dout_q, dout_d;
    logic [DATA_W-1:0]      rdata_q, rdata_d;
    logic                   ack_q, ack_d;
    logic                   busy_q, busy_d;
    logic                   ce_n_q, ce_n_d;
    logic                   oe_n_q, oe_n_d;
    logic                   we_n_q, we_n_d;
    logic                   ub_n_q, ub_n_d;
    logic                   lb_n_q, lb_n_d;
    logic                   data_oe_q, data_oe_d;

    logic                   req_is_io_c;
    logic                   io_wr_c;
    logic [DATA_W-1:0]      io_rd_c;

    assign req_is_io_c = (addr == ADDR_W'(IO_SW_ADDR)) || (addr == ADDR_W'(IO_LED_ADDR));
    assign io_wr_c     = (state_q == IO) && we_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        be_d     = be_q;
        sel_sw_d = sel_sw_q;
        addr_d   = addr_q;
        dout_d   = dout_q;
        rdata_d  = rdata_q;

        unique case (state_q)
            IDLE: begin
                if (req) begin
                    we_d     = we;
                    be_d     = be;
                    sel_sw_d = (addr == ADDR_W'(IO_SW_ADDR));
                    addr_d   = SRAM_ADDR_W'(addr);
                    cnt_d    = '0;
                    if (we) begin
                        dout_d = wdata;
                    end
                    if (req_is_io_c) begin
                        state_d = IO;
                    end else if (we) begin
                        state_d = WR_SETUP;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            IO: begin
                if (!we_q) begin
                    rdata_d = io_rd_c;
                end
                state_d = DONE;
            end
            RD: begin
                if (cnt_q == WC_LAST) begin
                    rdata_d = Data_in;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + WC_W'(1);
                end
            end
            WR_SETUP: state_d = WR;
            WR: begin
                if (cnt_q == WC_LAST) begin
                    state_d = WR_HOLD;
                end else begin
                    cnt_d = cnt_q + WC_W'(1);
                end
            end
            WR_HOLD:  state_d = DONE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase

        // Strobes are decoded from the next state so each flop lines up with its state.
        ack_d     = (state_d == DONE);
        busy_d    = (state_d != IDLE);
        ce_n_d    = !(state_d inside {RD, WR_SETUP, WR, WR_HOLD});
        oe_n_d    = (state_d != RD);
        we_n_d    = (state_d != WR);
        data_oe_d = (state_d inside {WR_SETUP, WR, WR_HOLD});
        ub_n_d    = 1'b1;
        lb_n_d    = 1'b1;
        if (state_d == RD) begin
            ub_n_d = 1'b0;
            lb_n_d = 1'b0;
        end else if (state_d == WR) begin
            ub_n_d = ~be_d[1];
            lb_n_d = ~be_d[0];
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            be_q      <= 2'b00;
            sel_sw_q  <= 1'b0;
            addr_q    <= '0;
            dout_q    <= '0;
            rdata_q   <= '0;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
            ce_n_q    <= 1'b1;
            oe_n_q    <= 1'b1;
            we_n_q    <= 1'b1;
            ub_n_q    <= 1'b1;
            lb_n_q    <= 1'b1;
            data_oe_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            be_q      <= be_d;
            sel_sw_q  <= sel_sw_d;
            addr_q    <= addr_d;
            dout_q    <= dout_d;
            rdata_q   <= rdata_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
            ce_n_q    <= ce_n_d;
            oe_n_q    <= oe_n_d;
            we_n_q    <= we_n_d;
            ub_n_q    <= ub_n_d;
            lb_n_q    <= lb_n_d;
            data_oe_q <= data_oe_d;
        end
    end

    mem_io_regs #(
        .DATA_W  (DATA_W),
        .NUM_HEX (NUM_HEX),
        .LED_W   (LED_W)
    ) u_regs (
        .clk       (Clk),
        .rst       (Reset),
        .wr_en     (io_wr_c),
        .sel_sw    (sel_sw_q),
        .wdata     (dout_q),
        .sw        (Switches),
        .hex       (HEX),
        .led       (LED),
        .rd_data_c (io_rd_c)
    );

    assign rdata    = rdata_q;
    assign ack      = ack_q;
    assign busy     = busy_q;
    assign CE       = ce_n_q;
    assign OE       = oe_n_q;
    assign WE       = we_n_q;
    assign UB       = ub_n_q;
    assign LB       = lb_n_q;
    assign ADDR     = addr_q;
    assign Data_out = dout_q;
    assign Data_oe  = data_oe_q;

endmodule

// File: tb/tb_mem_io_ctrl.sv
// Directed vector table plus hand-written corner sequences and random-traffic bus checks.
module tb_mem_io_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- main instance, WAIT_STATES = 2 ----------------
    logic        req = 1'b0, we = 1'b0;
    logic [1:0]  be = 2'b00;
    logic [15:0] addr = '0, wdata = '0, Switches = '0;
    logic [15:0] rdata, Data_out, Data_in;
    logic        ack, busy, CE, OE, WE, UB, LB, Data_oe;
    logic [15:0] HEX;
    logic [11:0] LED;
    logic [19:0] ADDR;
    logic [15:0] mem [256];

    assign Data_in = mem[ADDR[7:0]];

    mem_io_ctrl #(.WAIT_STATES(2)) u_dut (
        .Clk(clk), .Reset(rst), .req(req), .we(we), .be(be), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ack(ack), .busy(busy), .Switches(Switches), .HEX(HEX), .LED(LED),
        .CE(CE), .OE(OE), .WE(WE), .UB(UB), .LB(LB), .ADDR(ADDR), .Data_out(Data_out),
        .Data_oe(Data_oe), .Data_in(Data_in)
    );

    // ---------------- random-traffic instances, WAIT_STATES = 0,1,5 ----------------
    logic        r_req [3], r_we [3];
    logic [1:0]  r_be [3];
    logic [15:0] r_addr [3], r_wdata [3], r_sw [3], r_din [3];
    logic [15:0] r_rdata [3], r_dout [3], r_hex [3];
    logic [11:0] r_led [3];
    logic [19:0] r_addr_o [3];
    logic        r_ack [3], r_busy [3], r_ce [3], r_oe [3], r_wen [3], r_ub [3], r_lb [3], r_doe [3];

    for (genvar g = 0; g < 3; g++) begin : g_rnd
        mem_io_ctrl #(.WAIT_STATES((g == 0) ? 0 : ((g == 1) ? 1 : 5))) u_dut (
            .Clk(clk), .Reset(rst), .req(r_req[g]), .we(r_we[g]), .be(r_be[g]),
            .addr(r_addr[g]), .wdata(r_wdata[g]), .rdata(r_rdata[g]), .ack(r_ack[g]),
            .busy(r_busy[g]), .Switches(r_sw[g]), .HEX(r_hex[g]), .LED(r_led[g]),
            .CE(r_ce[g]), .OE(r_oe[g]), .WE(r_wen[g]), .UB(r_ub[g]), .LB(r_lb[g]),
            .ADDR(r_addr_o[g]), .Data_out(r_dout[g]), .Data_oe(r_doe[g]), .Data_in(r_din[g])
        );
    end

    // Bus-protocol checks on the random instances, sampled on the falling edge.
    logic        prev_ack [3], prev_ce [3], prev_we [3];
    int          ack_cnt [3];
    logic [63:0] sig = '0;

    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (rst) begin
                prev_ack[g] = 1'b0;
                prev_ce[g]  = 1'b1;
                prev_we[g]  = 1'b1;
            end else begin
                chk($sformatf("t6_contention_%0d", g), 32'(r_doe[g] & ~r_oe[g]), 32'd0);
                chk($sformatf("t6_ack_len_%0d", g), 32'(prev_ack[g] & r_ack[g]), 32'd0);
                chk($sformatf("t6_we_in_ce_%0d", g), 32'(~r_wen[g] & r_ce[g]), 32'd0);
                chk($sformatf("t6_we_first_%0d", g), 32'(~r_wen[g] & prev_ce[g]), 32'd0);
                chk($sformatf("t6_we_last_%0d", g), 32'(~prev_we[g] & r_ce[g]), 32'd0);
                chk($sformatf("t6_addr_hi_%0d", g), 32'(r_addr_o[g][19:16]), 32'd0);
                if (r_ack[g]) ack_cnt[g]++;
                sig = sig ^ {r_rdata[g], r_hex[g], r_dout[g], r_addr_o[g][15:0]}
                          ^ 64'({r_led[g], r_busy[g], r_ub[g], r_lb[g]});
                prev_ack[g] = r_ack[g];
                prev_ce[g]  = r_ce[g];
                prev_we[g]  = r_wen[g];
            end
        end
    end

    // One access on the main instance; counts strobe cycles and flags protocol violations.
    task automatic access(input logic iwe, input logic [1:0] ibe, input logic [15:0] iaddr,
                          input logic [15:0] iwdata, output int lat, output int ce_n,
                          output int oe_n, output int we_n, output logic [1:0] lanes,
                          output logic viol);
        logic done, pce, pwe;
        we = iwe; be = ibe; addr = iaddr; wdata = iwdata; req = 1'b1;
        lat = 0; ce_n = 0; oe_n = 0; we_n = 0; lanes = 2'b11; viol = 1'b0;
        done = 1'b0; pce = 1'b1; pwe = 1'b1;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            req = 1'b0;
            lat++;
            if (!CE) ce_n++;
            if (!OE) oe_n++;
            if (!WE) begin
                we_n++;
                lanes = {UB, LB};
                if (pce || CE || !Data_oe) viol = 1'b1;
                if (!CE) begin
                    if (!UB) mem[ADDR[7:0]][15:8] = Data_out[15:8];
                    if (!LB) mem[ADDR[7:0]][7:0]  = Data_out[7:0];
                end
            end
            if (!pwe && CE) viol = 1'b1;
            if (Data_oe && !OE) viol = 1'b1;
            if (!busy) viol = 1'b1;
            if (ack) begin
                done = 1'b1;
                if (Data_oe || !CE || !OE || !WE) viol = 1'b1;
            end
            pce = CE; pwe = WE;
        end
        @(posedge clk); #1;
        if (busy || ack) viol = 1'b1;
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  be;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] sw;
        logic [15:0] e_rdata;
        int          e_lat;
        int          e_ce;
        int          e_oe;
        int          e_we;
        logic [1:0]  e_lanes;
        logic [15:0] e_hex;
        logic [11:0] e_led;
    } vec_t;

    vec_t vt [13];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, ce_n, oe_n, we_n, n;
        logic [1:0] lanes;
        logic viol, busy_late;
        logic [8:0] ackv, busyv;

        for (int g = 0; g < 3; g++) begin
            r_req[g] = 1'b0; r_we[g] = 1'b0; r_be[g] = 2'b00; r_addr[g] = '0;
            r_wdata[g] = '0; r_sw[g] = '0; r_din[g] = '0; ack_cnt[g] = 0;
        end
        for (int i = 0; i < 256; i++) mem[i] = 16'(i * 3);
        mem[8'h30] = 16'hBEEF;
        mem[8'h40] = 16'hCD77;

        //         we    be     addr      wdata     sw        rdata   lat ce oe we lanes  hex       led
        vt[0]  = '{1'b0, 2'b11, 16'h0030, 16'h0000, 16'h0000, 16'hBEEF, 4, 3, 3, 0, 2'b11, 16'h0000, 12'h000};
        vt[1]  = '{1'b1, 2'b01, 16'h0040, 16'h1234, 16'h0000, 16'hBEEF, 6, 5, 0, 3, 2'b10, 16'h0000, 12'h000};
        vt[2]  = '{1'b0, 2'b11, 16'h0040, 16'h0000, 16'h0000, 16'hCD34, 4, 3, 3, 0, 2'b11, 16'h0000, 12'h000};
        vt[3]  = '{1'b1, 2'b00, 16'hFFFF, 16'h00A5, 16'h0000, 16'hCD34, 2, 0, 0, 0, 2'b11, 16'h00A5, 12'h000};
        vt[4]  = '{1'b0, 2'b11, 16'hFFFF, 16'h0000, 16'h5A5A, 16'h5A5A, 2, 0, 0, 0, 2'b11, 16'h00A5, 12'h000};
        vt[5]  = '{1'b1, 2'b11, 16'hFFFE, 16'hFFFF, 16'h0000, 16'h5A5A, 2, 0, 0, 0, 2'b11, 16'h00A5, 12'hFFF};
        vt[6]  = '{1'b0, 2'b00, 16'hFFFE, 16'h0000, 16'h1111, 16'h0FFF, 2, 0, 0, 0, 2'b11, 16'h00A5, 12'hFFF};
        vt[7]  = '{1'b1, 2'b00, 16'h0040, 16'hFFFF, 16'h0000, 16'h0FFF, 6, 5, 0, 3, 2'b11, 16'h00A5, 12'hFFF};
        vt[8]  = '{1'b0, 2'b11, 16'h0040, 16'h0000, 16'h0000, 16'hCD34, 4, 3, 3, 0, 2'b11, 16'h00A5, 12'hFFF};
        vt[9]  = '{1'b1, 2'b11, 16'h0050, 16'h9876, 16'h0000, 16'hCD34, 6, 5, 0, 3, 2'b00, 16'h00A5, 12'hFFF};
        vt[10] = '{1'b0, 2'b00, 16'h0050, 16'h0000, 16'h0000, 16'h9876, 4, 3, 3, 0, 2'b11, 16'h00A5, 12'hFFF};
        vt[11] = '{1'b1, 2'b10, 16'h0050, 16'h11EE, 16'h0000, 16'h9876, 6, 5, 0, 3, 2'b01, 16'h00A5, 12'hFFF};
        vt[12] = '{1'b0, 2'b11, 16'h0050, 16'h0000, 16'h0000, 16'h1176, 4, 3, 3, 0, 2'b11, 16'h00A5, 12'hFFF};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ctrl", 32'({CE, OE, WE, UB, LB, Data_oe, ack, busy}), 32'b1111_1000);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_hex", 32'(HEX), 32'd0);
        chk("rst_led", 32'(LED), 32'd0);
        chk("rst_addr", 32'(ADDR), 32'd0);
        chk("rst_dout", 32'(Data_out), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed vector table
        for (int i = 0; i < 13; i++) begin
            Switches = vt[i].sw;
            access(vt[i].we, vt[i].be, vt[i].addr, vt[i].wdata, lat, ce_n, oe_n, we_n, lanes, viol);
            chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vt[i].e_lat));
            chk($sformatf("v%0d_rdata", i), 32'(rdata), 32'(vt[i].e_rdata));
            chk($sformatf("v%0d_hex", i), 32'(HEX), 32'(vt[i].e_hex));
            chk($sformatf("v%0d_led", i), 32'(LED), 32'(vt[i].e_led));
            chk($sformatf("v%0d_addr", i), 32'(ADDR), 32'(vt[i].addr));
            chk($sformatf("v%0d_ce_cycles", i), 32'(ce_n), 32'(vt[i].e_ce));
            chk($sformatf("v%0d_oe_cycles", i), 32'(oe_n), 32'(vt[i].e_oe));
            chk($sformatf("v%0d_we_cycles", i), 32'(we_n), 32'(vt[i].e_we));
            chk($sformatf("v%0d_lanes", i), 32'(lanes), 32'(vt[i].e_lanes));
            chk($sformatf("v%0d_protocol", i), 32'(viol), 32'd0);
        end

        // Back-to-back reads with req held high, WAIT_STATES = 0
        r_we[0] = 1'b0; r_addr[0] = 16'h0010; r_req[0] = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            ackv[i]  = r_ack[0];
            busyv[i] = r_busy[0];
        end
        r_req[0] = 1'b0;
        chk("t4_ack_pattern", 32'(ackv), 32'h092);
        chk("t4_busy_pattern", 32'(busyv), 32'h0DB);

        // req kept high through RD and DONE must not start a second access
        @(posedge clk); #1;
        r_req[0] = 1'b1; n = 0; busy_late = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (i == 2) r_req[0] = 1'b0;
            if (r_ack[0]) n++;
            if (i >= 2 && r_busy[0]) busy_late = 1'b1;
        end
        chk("t4_ignored_acks", 32'(n), 32'd1);
        chk("t4_ignored_busy", 32'(busy_late), 32'd0);

        // Reset in the second WR cycle aborts the write without a clock edge
        we = 1'b1; be = 2'b11; addr = 16'h0060; wdata = 16'h5555; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("t5_we_low_before", 32'({WE, CE, Data_oe}), 32'b001);
        #2 rst = 1'b1;
        #1;
        chk("t5_abort_strobes", 32'({WE, CE, Data_oe}), 32'b110);
        n = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (ack) n++;
        end
        chk("t5_hex_cleared", 32'(HEX), 32'd0);
        rst = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (ack) n++;
        end
        chk("t5_no_ack", 32'(n), 32'd0);
        chk("t5_rdata_cleared", 32'(rdata), 32'd0);
        access(1'b0, 2'b11, 16'h0030, 16'h0000, lat, ce_n, oe_n, we_n, lanes, viol);
        chk("t5_after_lat", 32'(lat), 32'd4);
        chk("t5_after_rdata", 32'(rdata), 32'hBEEF);
        chk("t5_after_protocol", 32'(viol), 32'd0);

        // Random traffic on the three wait-state variants
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            for (int g = 0; g < 3; g++) begin
                int sel;
                sel        = int'($urandom_range(0, 3));
                r_req[g]   = 1'($urandom_range(0, 1));
                r_we[g]    = 1'($urandom_range(0, 1));
                r_be[g]    = 2'($urandom_range(0, 3));
                r_addr[g]  = (sel == 0) ? 16'hFFFF : ((sel == 1) ? 16'hFFFE : 16'($urandom_range(0, 255)));
                r_wdata[g] = 16'($urandom);
                r_sw[g]    = 16'($urandom);
                r_din[g]   = 16'($urandom);
            end
        end
        for (int g = 0; g < 3; g++) r_req[g] = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("t6_acks_seen_%0d", g), 32'(ack_cnt[g] > 0), 32'd1);
            chk($sformatf("t6_idle_%0d", g), 32'(r_busy[g]), 32'd0);
        end
        $display("random traffic signature %h", sig);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
